// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
package pc_seq_pkg;

    // Sequencer mode: hold at the reset vector, then fetch.
    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    // Source of the next program counter.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_SEQ  = 2'd1,
        SEL_JUMP = 2'd2,
        SEL_RET  = 2'd3
    } sel_e;

endpackage

// File: rtl/pc_seq_if.sv
// Fetch control bus between the PC sequencer and its fetch-stage client.
interface pc_seq_if #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic              branch_taken;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] w_instruction_address;
    logic [ADDR_W-1:0] pc_out;
    logic              pc_valid;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, branch_taken, call, ret, w_instruction_address,
        input  pc_out, pc_valid, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, call, ret, w_instruction_address,
        output pc_out, pc_valid, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [ADDR_W-1:0]                i_data,
    output logic [ADDR_W-1:0]                o_data_c,
    output logic [$clog2(RAS_DEPTH):0]       o_count,
    output logic                             o_full_c,
    output logic                             o_empty_c
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_top;

    // r_ptr is the next write slot; the top of stack sits just below it.
    assign w_top     = r_ptr - 1'b1;
    assign o_data_c  = r_mem[w_top];
    assign o_count   = r_count;
    assign o_full_c  = (r_count == CNT_W'(RAS_DEPTH));
    assign o_empty_c = (r_count == '0);

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    // Pointer and occupancy; the count saturates at depth on overwrite.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + 1'b1;
            if (!o_full_c) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_pop && !o_empty_c) begin
            r_ptr   <= r_ptr - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program counter with warm-up hold, stall, branch and call/return.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       STEP      = 1,
    parameter int unsigned       WARMUP    = 1,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    pc_seq_if.slave  bus
);
    localparam int unsigned CNT_W  = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int unsigned WLAST  = (WARMUP > 0) ? WARMUP - 1 : 0;

    state_e             r_state;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_valid;
    logic               r_ovf;
    logic               r_unf;

    sel_e               w_sel;
    logic               w_push;
    logic               w_pop;
    logic               w_ret_empty;
    logic [ADDR_W-1:0]  w_seq;
    logic [ADDR_W-1:0]  w_ras_data;
    logic [CNT_W-1:0]   w_ras_count;
    logic               w_ras_full;
    logic               w_ras_empty;

    assign w_seq = r_pc + ADDR_W'(STEP);

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_seq),
        .o_data_c  (w_ras_data),
        .o_count   (w_ras_count),
        .o_full_c  (w_ras_full),
        .o_empty_c (w_ras_empty)
    );

    // Next-PC source by priority: stall > ret > call > branch > sequential.
    always_comb begin
        w_sel       = SEL_HOLD;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ret_empty = 1'b0;
        if (r_state == ST_RUN && !bus.stall) begin
            if (bus.ret) begin
                if (w_ras_empty) begin
                    w_sel       = SEL_SEQ;
                    w_ret_empty = 1'b1;
                end else begin
                    w_sel = SEL_RET;
                    w_pop = 1'b1;
                end
            end else if (bus.call) begin
                w_sel  = SEL_JUMP;
                w_push = 1'b1;
            end else if (bus.branch_taken) begin
                w_sel = SEL_JUMP;
            end else begin
                w_sel = SEL_SEQ;
            end
        end
    end

    // Mode FSM, PC register and sticky stack-error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            r_wcnt  <= '0;
            r_pc    <= RESET_VEC;
            r_valid <= (WARMUP == 0);
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (r_wcnt == WCNT_W'(WLAST)) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    case (w_sel)
                        SEL_SEQ:  r_pc <= w_seq;
                        SEL_JUMP: r_pc <= bus.w_instruction_address;
                        SEL_RET:  r_pc <= w_ras_data;
                        default:  r_pc <= r_pc;
                    endcase
                    if (w_push && w_ras_full) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_ret_empty) begin
                        r_unf <= 1'b1;
                    end
                end
                default: r_state <= ST_WARMUP;
            endcase
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.pc_valid      = r_valid;
    assign bus.ras_count     = w_ras_count;
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: two configurations driven with directed and random redirects.
module tb_pc_seq;

    typedef struct {
        int unsigned pc;
        bit          valid;
        int unsigned cnt;
        bit          ovf;
        bit          unf;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // Per-configuration input drives and observed outputs (index 0: 16-bit, 1: 8-bit).
    logic        st [2];
    logic        rt [2];
    logic        ca [2];
    logic        br [2];
    logic [15:0] tg [2];
    logic [15:0] o_pc [2];
    logic        o_valid [2];
    logic [2:0]  o_cnt [2];
    logic        o_ovf [2];
    logic        o_unf [2];

    pc_seq_if #(.ADDR_W(16), .RAS_DEPTH(4)) ifa ();
    pc_seq_if #(.ADDR_W(8),  .RAS_DEPTH(2)) ifb ();

    pc_seq #(.ADDR_W(16), .RESET_VEC(16'h0100), .STEP(1), .WARMUP(1), .RAS_DEPTH(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa));
    pc_seq #(.ADDR_W(8), .RESET_VEC(8'hF0), .STEP(4), .WARMUP(3), .RAS_DEPTH(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb));

    assign ifa.stall = st[0];
    assign ifa.ret = rt[0];
    assign ifa.call = ca[0];
    assign ifa.branch_taken = br[0];
    assign ifa.w_instruction_address = tg[0];
    assign ifb.stall = st[1];
    assign ifb.ret = rt[1];
    assign ifb.call = ca[1];
    assign ifb.branch_taken = br[1];
    assign ifb.w_instruction_address = tg[1][7:0];

    assign o_pc[0] = ifa.pc_out;
    assign o_valid[0] = ifa.pc_valid;
    assign o_cnt[0] = ifa.ras_count;
    assign o_ovf[0] = ifa.ras_overflow;
    assign o_unf[0] = ifa.ras_underflow;
    assign o_pc[1] = {8'h00, ifb.pc_out};
    assign o_valid[1] = ifb.pc_valid;
    assign o_cnt[1] = {1'b0, ifb.ras_count};
    assign o_ovf[1] = ifb.ras_overflow;
    assign o_unf[1] = ifb.ras_underflow;

    int n_tests = 0;
    int n_fail = 0;

    // Behavioural model state: the RAS is just a bounded list of return addresses.
    int unsigned m_pc [2];
    int unsigned m_wrem [2];
    bit          m_valid [2];
    bit          m_ovf [2];
    bit          m_unf [2];
    int unsigned m_ras [2][$];
    exp_t        exp_q [2][$];

    function automatic int unsigned p_mask(input int d);
        return (d == 0) ? 32'hFFFF : 32'h00FF;
    endfunction
    function automatic int unsigned p_rvec(input int d);
        return (d == 0) ? 32'h0100 : 32'h00F0;
    endfunction
    function automatic int unsigned p_step(input int d);
        return (d == 0) ? 1 : 4;
    endfunction
    function automatic int unsigned p_warm(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int p_depth(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic model_reset(input int d);
        m_pc[d]    = p_rvec(d);
        m_wrem[d]  = p_warm(d);
        m_valid[d] = (p_warm(d) == 0);
        m_ovf[d]   = 1'b0;
        m_unf[d]   = 1'b0;
        m_ras[d].delete();
    endtask

    task automatic model_step(input int d);
        int unsigned seq;
        int unsigned dropped;
        seq = (m_pc[d] + p_step(d)) & p_mask(d);
        if (m_wrem[d] > 0) begin
            m_wrem[d] = m_wrem[d] - 1;
            if (m_wrem[d] == 0) m_valid[d] = 1'b1;
        end else if (st[d]) begin
            m_pc[d] = m_pc[d];
        end else if (rt[d]) begin
            if (m_ras[d].size() > 0) begin
                m_pc[d] = m_ras[d].pop_back();
            end else begin
                m_pc[d]  = seq;
                m_unf[d] = 1'b1;
            end
        end else if (ca[d]) begin
            m_ras[d].push_back(seq);
            if (m_ras[d].size() > p_depth(d)) begin
                dropped  = m_ras[d].pop_front();
                m_ovf[d] = 1'b1;
            end
            m_pc[d] = 32'(tg[d]) & p_mask(d);
        end else if (br[d]) begin
            m_pc[d] = 32'(tg[d]) & p_mask(d);
        end else begin
            m_pc[d] = seq;
        end
    endtask

    task automatic push_exp(input int d);
        exp_t e;
        e.pc    = m_pc[d];
        e.valid = m_valid[d];
        e.cnt   = 32'(m_ras[d].size());
        e.ovf   = m_ovf[d];
        e.unf   = m_unf[d];
        exp_q[d].push_back(e);
    endtask

    // One clock: advance the model on the edge, queue what the DUT must show, then release inputs for re-drive.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) model_reset(d);
            else model_step(d);
            push_exp(d);
        end
        #1;
    endtask

    task automatic set_in(input int d, input logic s, input logic r, input logic c,
                          input logic b, input logic [15:0] t);
        st[d] = s; rt[d] = r; ca[d] = c; br[d] = b; tg[d] = t;
    endtask

    task automatic clear_in();
        for (int d = 0; d < 2; d++) set_in(d, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic rand_in();
        for (int d = 0; d < 2; d++)
            set_in(d, ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
                   ($urandom % 4) == 0, 16'($urandom & p_mask(d)));
    endtask

    task automatic expect_pc(input int d, input int unsigned v, input string nm);
        @(negedge clk);
        #1;
        n_tests++;
        if (32'(o_pc[d]) != v) begin
            n_fail++;
            $display("FAIL %s: pc_out got %h expected %h", nm, o_pc[d], v);
        end
    endtask

    // Asynchronous reset between edges: outputs must drop before the next clock.
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (32'(o_pc[d]) != p_rvec(d) || o_cnt[d] != 3'd0 || o_ovf[d] || o_unf[d]) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: pc=%h cnt=%0d ovf=%0b unf=%0b expected pc=%h cnt=0 flags=0",
                         d, o_pc[d], o_cnt[d], o_ovf[d], o_unf[d], p_rvec(d));
            end
            exp_q[d].delete();
            model_reset(d);
            push_exp(d);
        end
        cycle();
        reset_n = 1'b1;
    endtask

    // Monitor: each falling edge, compare the DUT against the queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (exp_q[d].size() > 0) begin
                exp_t e;
                e = exp_q[d].pop_front();
                n_tests++;
                if (32'(o_pc[d]) != e.pc || o_valid[d] != e.valid || 32'(o_cnt[d]) != e.cnt ||
                    o_ovf[d] != e.ovf || o_unf[d] != e.unf) begin
                    n_fail++;
                    $display("FAIL scoreboard[%0d] t=%0t: got pc=%h valid=%0b cnt=%0d ovf=%0b unf=%0b expected pc=%h valid=%0b cnt=%0d ovf=%0b unf=%0b",
                             d, $time, o_pc[d], o_valid[d], o_cnt[d], o_ovf[d], o_unf[d],
                             e.pc, e.valid, e.cnt, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clear_in();
        cycle();
        reset_n = 1'b1;

        // Warm-up then sequential fetch from the reset vector.
        cycle(); cycle(); cycle();
        expect_pc(0, 32'h0102, "warmup_seq");

        // Branch followed by a stall.
        set_in(0, 0, 0, 0, 1, 16'h0010); cycle();
        set_in(0, 0, 0, 0, 1, 16'h0040); cycle();
        set_in(0, 1, 0, 0, 0, 16'h0000); cycle();
        clear_in(); cycle();
        expect_pc(0, 32'h0041, "branch_stall");

        // Call then return three cycles later.
        set_in(0, 0, 0, 0, 1, 16'h0010); cycle();
        set_in(0, 0, 0, 1, 0, 16'h0200); cycle();
        clear_in(); cycle(); cycle();
        set_in(0, 0, 1, 0, 0, 16'h0000); cycle();
        expect_pc(0, 32'h0011, "call_ret");

        // Five nested calls overflow a 4-deep stack; the fifth return underflows.
        for (int k = 1; k <= 5; k++) begin
            set_in(0, 0, 0, 1, 0, 16'(k * 32'h1000)); cycle();
        end
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 1, 1, 0, 16'h7777); cycle();
        end
        clear_in();
        expect_pc(0, 32'h1002, "ras_overflow_underflow");

        // 8-bit wrap with STEP=4, including a wrapped return address.
        set_in(1, 0, 0, 0, 1, 16'h00FC); cycle();
        clear_in(); cycle();
        expect_pc(1, 32'h0000, "wrap_seq");
        set_in(1, 0, 0, 0, 1, 16'h00FC); cycle();
        set_in(1, 0, 0, 1, 0, 16'h0030); cycle();
        set_in(1, 0, 1, 0, 0, 16'h0000); cycle();
        clear_in();
        expect_pc(1, 32'h0000, "wrap_call_ret");

        // Random traffic with asynchronous resets mid-run.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1000 || i == 2000) async_reset();
            rand_in();
            cycle();
        end

        clear_in();
        cycle();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer, the next-generation PC for the fetch stage. It generalises address width, reset vector, increment step and post-reset warm-up length, and adds stall and a hardware return-address stack (RAS) for call/return. It drives the instruction-memory address and a valid qualifier to fetch.

## Interface
- ADDR_W, 16, PC and target width.
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits).
- STEP, 1, sequential increment per instruction.
- WARMUP, 1, cycles PC is held at RESET_VEC after reset release (0 = run immediately).
- RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).
- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC; ignores all redirects this cycle.
- branch_taken  in  1  redirect to w_instruction_address.
- call  in  1  redirect to w_instruction_address and push return address.
- ret  in  1  redirect to popped return address.
- w_instruction_address  in  ADDR_W  branch/call target.
- pc_out  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc_out is a real fetch address (low during warm-up).
- ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries.
- ras_overflow  out  1  sticky: push occurred while full.
- ras_underflow  out  1  sticky: pop occurred while empty.

## Operation
- FSM states: WARMUP, RUN. Reset enters WARMUP (RUN if WARMUP=0) with warm-up counter = 0.
- WARMUP: pc_out held at RESET_VEC, pc_valid=0, redirect inputs and stall ignored, counter increments each cycle; on counter = WARMUP-1 move to RUN.
- RUN, next-PC priority (highest first):
  - stall: hold pc_out, no RAS change.
  - ret: pc_out ← RAS top, pop. If empty: pc_out ← pc_out+STEP, set ras_underflow, count stays 0.
  - call: pc_out ← w_instruction_address, push pc_out+STEP.
  - branch_taken: pc_out ← w_instruction_address.
  - else pc_out ← pc_out+STEP.
- Lower-priority inputs asserted together with a higher one are ignored (ret+call → pure ret).
- Arithmetic modulo 2^ADDR_W; pc_out+STEP and return addresses wrap silently.
- RAS is circular: push while full overwrites the oldest entry, count stays RAS_DEPTH, ras_overflow set. Overflowed entries are lost; later pops return newer entries only.
- Sticky flags clear only on reset.

## Timing
- Reset values: pc_out=RESET_VEC, pc_valid=0 (1 if WARMUP=0), ras_count=0, ras_overflow=0, ras_underflow=0, RAS contents don't-care.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous), RAS emptied.
- pc_valid rises in the same cycle the FSM enters RUN; pc_out=RESET_VEC on the first valid cycle.
- Redirect latency: one cycle. Inputs sampled at edge N set pc_out after edge N.
- All outputs registered; no combinational input→output path.

## Structure
- Package pc_seq_pkg holds the FSM state enum (ST_WARMUP, ST_RUN) and the next-PC select enum (SEL_HOLD, SEL_SEQ, SEL_JUMP, SEL_RET).
- Sub-module pc_ras: a circular LIFO with push/pop/data/count/full/empty, parametrised by ADDR_W and RAS_DEPTH. Same-cycle push+pop never occurs, because priority excludes it.

## Test plan
- Reset with WARMUP=1, RESET_VEC=0x0100, no inputs -> pc_out 0x0100 for 2 cycles (pc_valid 0 then 1), then 0x0101, 0x0102.
- In RUN at 0x0010, branch_taken with target 0x0040, stall on the next cycle -> pc_out 0x0040 held two cycles, then 0x0041.
- call to 0x0200 from 0x0010, then ret 3 cycles later -> 0x0200, 0x0201, 0x0202, 0x0011; ras_count 1 then 0.
- RAS_DEPTH=4, five nested calls, then five rets -> ras_overflow=1 after the fifth call; four rets return in LIFO order (oldest lost); fifth ret gives pc+1 with ras_underflow=1.
- ADDR_W=8, STEP=4, pc 0xFC -> next 0x00; call at 0xFC pushes 0x00.
- reset_n pulsed low asynchronously mid-call-sequence -> pc_out=RESET_VEC, ras_count=0, flags cleared before the next clock edge.
